dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
Two-requester arbiter and sequencer in front of the single-ported byte-addressed data memory. Requester 0 is the pipeline MEM stage (CPU). Requester 1 is the program-loader/debug port. The block grants at most one access per cycle and drives the memory's 3-bit op/address/write-data bus. It returns registered read data one cycle later to the granted requester, and flags misaligned or illegal ops before they reach the array.

Parameters:
MAX_WAIT, 4, max consecutive cycles loader may be held off by CPU before forced grant (1..15)
ADDR_W, 32, requester/memory address width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
c_valid  in  1  CPU request valid
c_ready  out  1  CPU request accepted this cycle (combinational)
c_op  in  3  000 lw, 010 lb, 110 lbu, 001 sw, 011 sb
c_addr  in  ADDR_W  CPU byte address
c_wdata  in  32  CPU store data
c_rvalid  out  1  CPU response pulse
c_rdata  out  32  CPU load data
c_err  out  1  CPU response error (valid with c_rvalid)
l_valid, l_ready, l_op, l_addr, l_wdata, l_rvalid, l_rdata, l_err  same widths/meaning for loader port
m_op  out  3  memory op/write-enable code (same encoding)
m_addr  out  ADDR_W  memory address
m_wdata  out  32  memory write data
m_rdata  in  32  memory async read data

Behaviour:
- Reset (rst_n low, async): c_rvalid=l_rvalid=0, c_rdata=l_rdata=0, c_err=l_err=0, wait_cnt=0, resp state=IDLE. c_ready=l_ready=0 while rst_n low. In-flight response is dropped and never emitted.
- Idle bus (no grant): m_op=000, m_addr=0, m_wdata=0. The memory never sees a write code unless a legal store is granted.
- Arbitration, combinational each cycle:
  - Only c_valid set: grant CPU.
  - Only l_valid set: grant loader.
  - Both set and wait_cnt<MAX_WAIT: grant CPU.
  - Both set and wait_cnt==MAX_WAIT: grant loader.
  - ready asserted only to the granted requester, same cycle. Transfer occurs when valid&&ready.
- wait_cnt, 4 bits:
  - +1 when l_valid=1 and CPU granted.
  - Cleared when loader granted or l_valid=0.
  - Saturates at MAX_WAIT.
- Legality check on the granted request:
  - Illegal op (100,101,111): error.
  - lw/sw with addr[1:0]!=00: error.
  - Error request: m_op forced 000 (no write), response err=1, rdata=0.
- Legal request: m_op/m_addr/m_wdata pass through from the granted requester in the grant cycle. Store commits at that clock edge.
- Response, latency 1:
  - On the grant edge, state moves to RESP_CPU or RESP_LD.
  - Granted port's rdata <= m_rdata for loads, 0 for stores. err is latched.
  - Next cycle the granted port's rvalid=1 for exactly one cycle. The other port's rvalid=0.
  - rdata/err hold until the next response to that port.
- Response FSM, IDLE/RESP_CPU/RESP_LD:
  - Next state = grant owner, or IDLE if no grant.
  - Back-to-back grants are allowed every cycle with no bubble, so responses pipeline 1:1 with grants.
- Simultaneous CPU store and loader read to the same address: only one is granted; the other sees ready=0 and must hold valid and all fields stable.
- Requesters may not change op/addr/wdata while valid&&!ready (bench asserts this).

Test Plan:
- Reset mid-access: CPU lw granted at 0x10, rst_n low before next edge -> c_rvalid never pulses; all outputs 0; first request after release is granted normally.
- CPU sw 0xDEADBEEF @0x100, then lw @0x100 next cycle -> c_ready=1 both cycles; c_rvalid pulses 2 cycles after the sw with c_rdata=0 then 0xDEADBEEF; lb @0x103 -> 0xFFFFFFDE; lbu @0x103 -> 0x000000DE.
- Both valid continuously, MAX_WAIT=4 -> grant sequence CPU,CPU,CPU,CPU,LD,CPU... ; l_ready high exactly every 5th cycle; wait_cnt returns to 0 after the LD grant.
- Loader-only sb 0x5A @0x201 while CPU idle -> l_ready=1 same cycle, m_op=011, l_rvalid next cycle with l_err=0; CPU lbu @0x201 -> 0x0000005A.
- CPU sw @0x102 (misaligned) and op 101 @0x0 -> m_op stays 000, no memory change (lw @0x100 unchanged), c_err=1 and c_rdata=0 on each response.
- Loader drops l_valid after 3 held cycles, reasserts -> wait_cnt restarts from 0; forced grant comes only after 4 further CPU-won cycles.

Source files
------------

// File: rtl/dmem_port_if.sv
// Requester-side handshake bundle for the data-memory arbiter.
// One instance per requester (CPU MEM stage, loader/debug port).
interface dmem_port_if #(
  parameter int ADDR_W = 32
);
  logic              valid;
  logic              ready;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output valid, op, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  valid, op, addr, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter/sequencer for the single-ported data memory.
// CPU has priority; the loader is force-granted after MAX_WAIT losses.
module dmem_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_port_if.slave        c,
  dmem_port_if.slave        l,
  output logic [2:0]        m_op,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    RESP_CPU,
    RESP_LD
  } state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              gnt_c;
  logic              gnt_l;
  logic              gnt;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              bad_op;
  logic              mis;
  logic              err;
  logic [31:0]       rsp;

  always_comb begin
    gnt_l  = rst_n & l.valid
           & (~c.valid | (wait_cnt == MAX_W));
    gnt_c  = rst_n & c.valid & ~gnt_l;
    gnt    = gnt_c | gnt_l;
    op     = gnt_l ? l.op    : c.op;
    addr   = gnt_l ? l.addr  : c.addr;
    wdata  = gnt_l ? l.wdata : c.wdata;
    bad_op = (op == 3'b100) | (op == 3'b101)
           | (op == 3'b111);
    mis    = ((op == 3'b000) | (op == 3'b001))
           & (addr[1:0] != 2'b00);
    err    = bad_op | mis;
    // stores and errored requests return zero data
    rsp    = (err | op[0]) ? 32'h0 : m_rdata;
    m_op    = 3'b000;
    m_addr  = '0;
    m_wdata = '0;
    if (gnt && !err) begin
      m_op    = op;
      m_addr  = addr;
      m_wdata = wdata;
    end
  end

  assign c.ready  = gnt_c;
  assign l.ready  = gnt_l;
  assign c.rvalid = (state == RESP_CPU);
  assign l.rvalid = (state == RESP_LD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      c.rdata  <= '0;
      c.err    <= 1'b0;
      l.rdata  <= '0;
      l.err    <= 1'b0;
    end else begin
      unique case (1'b1)
        gnt_c:   state <= RESP_CPU;
        gnt_l:   state <= RESP_LD;
        default: state <= IDLE;
      endcase
      if (l.valid && gnt_c) begin
        if (wait_cnt >= MAX_W) wait_cnt <= MAX_W;
        else                   wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= '0;
      end
      if (gnt_c) begin
        c.rdata <= rsp;
        c.err   <= err;
      end
      if (gnt_l) begin
        l.rdata <= rsp;
        l.err   <= err;
      end
    end
  end

endmodule
